// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader.
//
// Build option: define BRAM_STREAM_READER_OUTREG_EN when the BRAM has its
// output register enabled. Read latency then grows from 1 to 2 cycles and
// the skid FIFO grows with it, so one beat per cycle is still sustained.
package bram_stream_reader_pkg;

`ifdef BRAM_STREAM_READER_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // Two extra entries cover the round trip from a pop freeing a slot to
    // the matching read data arriving, so the stream never bubbles.
    localparam int FIFO_DEPTH = RD_LAT + 2;

    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // FIFO entry layout at the default word width; the top re-declares the
    // same layout at its own DATA_W.
    typedef struct packed {
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/bram_stream_fifo.sv
// Small synchronous FIFO that holds returning read data until the consumer
// takes it.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (storage cleared)
//   push_i, din_i   write one entry
//   pop_i           remove head entry (caller guarantees non-empty)
//   dout_o          head entry
//   empty_o         no entries held
//   count_o         number of entries held
module bram_stream_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= bump(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= bump(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read initiator for a single-port read-first BRAM. Takes a
// {start address, length} command, streams sequential reads from the RAM
// port and presents the data as a valid/ready stream tagged with m_last.
//
// Build option: BRAM_STREAM_READER_OUTREG_EN (see package) selects read
// latency 2 / FIFO depth 4 instead of latency 1 / depth 3.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (accepted only idle)
//   cmd_addr, cmd_len                first word, word count 0..2**ADDR_W
//   ram_en, ram_we, ram_addr, ram_di RAM port (write side tied off)
//   ram_do                           RAM read data, RD_LAT cycles after en
//   m_valid/m_ready, m_data, m_last  output stream
//   busy                             burst in progress
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;

    // Issue history: bit i set means a read issued i+1 cycles ago.
    logic [RD_LAT-1:0] vld_pipe_q, last_pipe_q;

    logic [CNT_W-1:0]  fifo_count, inflight;
    logic              credit_ok, issue, push, pop, fifo_empty;
    entry_t            wr_entry, rd_entry;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_pipe_q[i]);
    end

    // Only registered occupancy feeds the credit check, so m_ready has no
    // combinational route to the RAM port.
    assign credit_ok = (int'(fifo_count) + int'(inflight) + 1) <= FIFO_DEPTH;
    assign issue     = (state_q == ST_READ) && (rem_q != '0) && credit_ok;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len != '0) state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);   // wraps modulo depth
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == 1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && rd_entry.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            rem_q          <= rem_d;
            vld_pipe_q[0]  <= issue;
            last_pipe_q[0] <= issue && (rem_q == 1);
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
        end
    end

    assign push          = vld_pipe_q[RD_LAT-1];
    assign pop           = m_valid && m_ready;
    assign wr_entry.last = last_pipe_q[RD_LAT-1];
    assign wr_entry.data = ram_do;

    bram_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W+1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (wr_entry),
        .pop_i   (pop),
        .dout_o  (rd_entry),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign ram_en    = issue;
    assign ram_we    = 1'b0;
    assign ram_addr  = addr_q;
    assign ram_di    = '0;
    assign m_valid   = !fifo_empty;
    assign m_data    = rd_entry.data;
    assign m_last    = rd_entry.last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural read-first BRAM.
module tb_bram_stream_reader;
    import bram_stream_reader_pkg::*;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_do;
    logic          m_valid, m_ready, m_data_dummy;
    logic [DW-1:0] m_data;
    logic          m_last, busy;

    int checks = 0;
    int errors = 0;

    int          got_addr [$];
    logic [DW-1:0] got_data [$];
    logic        got_last [$];

    always #5 clk = ~clk;

    bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_do    (ram_do),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy)
    );

    // Behavioural BRAM: read-first, optional output register.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] q1, q2;
    always @(posedge clk) begin
        if (ram_en) q1 <= mem[ram_addr];
        q2 <= q1;
    end
    assign ram_do = (RD_LAT == 1) ? q1 : q2;
    assign m_data_dummy = 1'b0;

    function automatic logic [DW-1:0] pat(input int i);
        return 16'h1000 + 16'(i * 17);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_ram_en"},    32'(ram_en),    0);
        chk({tag, "_ram_addr"},  32'(ram_addr),  0);
        chk({tag, "_m_valid"},   32'(m_valid),   0);
        chk({tag, "_m_data"},    32'(m_data),    0);
        chk({tag, "_m_last"},    32'(m_last),    0);
        chk({tag, "_busy"},      32'(busy),      0);
    endtask

    // Issue one command and collect the burst. mode 0: always ready,
    // 1: stalled for the first 10 cycles, 2: random ready.
    task automatic run_burst(input string tag, input int a, input int len, input int mode);
        int k = 0, issued = 0, popped = 0, stall_en = 0;
        int credit_bad = 0, hold_bad = 0, tie_bad = 0;
        logic done = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
        logic [DW-1:0] prev_data = '0;
        got_addr.delete(); got_data.delete(); got_last.delete();
        cmd_valid = 1'b1; cmd_addr = AW'(a); cmd_len = (AW+1)'(len); m_ready = 1'b1;
        smp();
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        nxt();
        cmd_valid = 1'b0;
        while (!done && k < 1000) begin
            k++;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k > 10);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            smp();
            if (ram_we !== 1'b0 || ram_di !== '0) tie_bad++;
            if (ram_en) begin
                if (issued - popped >= FIFO_DEPTH) credit_bad++;
                issued++;
                got_addr.push_back(int'(ram_addr));
                if (mode == 1 && k <= 10) stall_en++;
            end
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) hold_bad++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                popped++;
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                if (m_last) done = 1'b1;
            end
            nxt();
        end
        chk({tag, "_done"}, 32'(done), 1);
        smp();
        chk({tag, "_busy_after"},  32'(busy),      0);
        chk({tag, "_ready_after"}, 32'(cmd_ready), 1);
        chk({tag, "_valid_after"}, 32'(m_valid),   0);
        chk({tag, "_n_reads"},  32'(got_addr.size()), 32'(len));
        chk({tag, "_n_beats"},  32'(got_data.size()), 32'(len));
        chk({tag, "_credit"},   32'(credit_bad), 0);
        chk({tag, "_hold"},     32'(hold_bad),   0);
        chk({tag, "_tieoff"},   32'(tie_bad),    0);
        if (mode == 1) chk({tag, "_stall_reads"}, 32'(stall_en), 32'(FIFO_DEPTH));
        for (int i = 0; i < len && i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(pat((a + i) % 64)));
            chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == len - 1));
        end
        for (int i = 0; i < len && i < got_addr.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'((a + i) % 64));
        nxt();
    endtask

    initial begin
        int beats, k, idle_bad;
        for (int i = 0; i < 64; i++) mem[i] = pat(i);
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;

        // Reset state
        smp();
        chk_reset_outputs("reset");
        nxt();
        rst_n = 1'b1;
        nxt();

        // Cycle-exact burst: addr 5, len 4, always ready
        cmd_valid = 1'b1; cmd_addr = 6'd5; cmd_len = 7'd4; m_ready = 1'b1;
        smp();
        chk("t1_c0_ready", 32'(cmd_ready), 1);
        chk("t1_c0_en",    32'(ram_en),    0);
        nxt();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 6 + RD_LAT; c++) begin
            logic en_e, v_e;
            smp();
            en_e = (c <= 4);
            v_e  = (c >= 2 + RD_LAT) && (c <= 5 + RD_LAT);
            chk($sformatf("t1_c%0d_en", c), 32'(ram_en), 32'(en_e));
            if (en_e) chk($sformatf("t1_c%0d_addr", c), 32'(ram_addr), 32'(5 + c - 1));
            chk($sformatf("t1_c%0d_valid", c), 32'(m_valid), 32'(v_e));
            if (v_e) begin
                chk($sformatf("t1_c%0d_data", c), 32'(m_data), 32'(pat(5 + c - 2 - RD_LAT)));
                chk($sformatf("t1_c%0d_last", c), 32'(m_last), 32'(c == 5 + RD_LAT));
            end
            chk($sformatf("t1_c%0d_busy", c), 32'(busy), 32'(c <= 5 + RD_LAT));
            nxt();
        end

        // Address wrap
        run_burst("wrap", 62, 4, 0);

        // Backpressure: 10 stalled cycles
        run_burst("stall", 10, 8, 1);

        // Random ready over a full-depth burst
        run_burst("rand", 17, 64, 2);

        // Zero-length command does nothing
        cmd_valid = 1'b1; cmd_addr = 6'd3; cmd_len = 7'd0; m_ready = 1'b1;
        nxt();
        cmd_valid = 1'b0;
        idle_bad = 0;
        for (int c = 0; c < 6; c++) begin
            smp();
            if (ram_en || m_valid || !cmd_ready || busy) idle_bad++;
            nxt();
        end
        chk("len0_idle", 32'(idle_bad), 0);

        // Single-word burst
        run_burst("len1", 9, 1, 0);

        // Reset during the third beat of a 10-word burst
        cmd_valid = 1'b1; cmd_addr = 6'd20; cmd_len = 7'd10; m_ready = 1'b1;
        nxt();
        cmd_valid = 1'b0;
        beats = 0; k = 0;
        while (beats < 3 && k < 50) begin
            smp();
            if (m_valid && m_ready) beats++;
            if (beats < 3) nxt();
            k++;
        end
        chk("midrst_reach", 32'(beats), 3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        nxt();
        rst_n = 1'b1;
        idle_bad = 0;
        for (int c = 0; c < 5; c++) begin
            smp();
            if (ram_en || m_valid || busy) idle_bad++;
            nxt();
        end
        chk("midrst_quiet", 32'(idle_bad), 0);
        run_burst("after_rst", 0, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
